// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC twiddle-table sequencer.
// Angles are binary radians: 2^ANGLE_W spans a full turn.
package cordic_pkg;

  localparam int ANGLE_W = 32;
  localparam int AMP     = 32000;

  localparam logic [31:0] ANG_90  = 32'h4000_0000;
  localparam logic [31:0] ANG_180 = 32'h8000_0000;

  // Tag index field is sized for the largest supported table (LOG2N <= IDX_W).
  localparam int IDX_W = 16;

  typedef enum logic [1:0] {
    Q_I   = 2'b00,
    Q_II  = 2'b01,
    Q_III = 2'b10,
    Q_IV  = 2'b11
  } quadrant_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fill_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             neg;
  } tag_t;

endpackage

// File: rtl/cordic_tag_delay.sv
// Fixed-depth shift register that carries side-band tags alongside the
// CORDIC core pipeline; a synchronous clear empties every stage.
module cordic_tag_delay
  import cordic_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 18
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/cordic_twiddle_gen.sv
// Sequences angles -2*pi*k/N (or +2*pi*k/N) into a rotation-mode CORDIC core
// and writes the sign-corrected cos/sin results into the FFT twiddle RAM.
module cordic_twiddle_gen #(
  parameter int LOG2N      = 8,
  parameter int WIDTH      = 16,
  parameter int ANGLE_W    = cordic_pkg::ANGLE_W,
  parameter int CORDIC_LAT = 16,
  parameter int AMP        = cordic_pkg::AMP
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_inverse,
  output logic [ANGLE_W-1:0]      o_angle,
  output logic [WIDTH-1:0]        o_x_start,
  output logic [WIDTH-1:0]        o_y_start,
  input  logic [WIDTH-1:0]        i_cosine,
  input  logic [WIDTH-1:0]        i_sine,
  output logic                    o_tw_we,
  output logic [LOG2N-1:0]        o_tw_addr,
  output logic [WIDTH-1:0]        o_tw_cos,
  output logic [WIDTH-1:0]        o_tw_sin,
  output logic                    o_busy,
  output logic                    o_done,
  output cordic_pkg::fill_state_e o_state
);

  localparam int IDX_W = cordic_pkg::IDX_W;
  localparam logic [LOG2N-1:0] K_LAST = '1;

  // start/busy handshake: start is accepted only in a cycle where busy=0 and
  // done=0; once accepted, busy stays high until the cycle done pulses.
  cordic_pkg::fill_state_e r_state, w_state_next;
  logic [LOG2N-1:0]        r_k, w_k_next;
  logic                    r_inverse, w_inv_sel;
  logic                    w_accept, w_issue, w_last_wr;
  logic [ANGLE_W-1:0]      r_angle, w_raw, w_theta, w_angle;
  cordic_pkg::quadrant_e   w_quad;
  logic                    w_neg;
  cordic_pkg::tag_t        r_tag, w_tag_out;
  logic                    r_done;
  logic                    r_tw_we;
  logic [LOG2N-1:0]        r_tw_addr;
  logic [WIDTH-1:0]        r_tw_cos, r_tw_sin;
  logic                    w_unused_idx;

  function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] min_v;
    min_v = {1'b1, {(WIDTH-1){1'b0}}};
    return (v == min_v) ? ~v : -v;
  endfunction

  assign w_last_wr = r_tw_we && (r_tw_addr == K_LAST);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_k_next     = r_k;
    w_inv_sel    = r_inverse;
    case (r_state)
      cordic_pkg::ST_IDLE: begin
        if (i_start && !r_done) begin
          w_accept     = 1'b1;
          w_issue      = 1'b1;
          w_k_next     = '0;
          w_inv_sel    = i_inverse;
          w_state_next = cordic_pkg::ST_ISSUE;
        end
      end
      cordic_pkg::ST_ISSUE: begin
        if (r_k == K_LAST) begin
          w_state_next = cordic_pkg::ST_DRAIN;
        end else begin
          w_issue  = 1'b1;
          w_k_next = r_k + 1'b1;
        end
      end
      cordic_pkg::ST_DRAIN: begin
        if (w_last_wr) w_state_next = cordic_pkg::ST_IDLE;
      end
      default: w_state_next = cordic_pkg::ST_IDLE;
    endcase
  end

  // Quadrants II/III are rotated by 180 degrees into the core's +-90 degree
  // range; the results are negated on the way out to compensate.
  assign w_raw   = {w_k_next, {(ANGLE_W-LOG2N){1'b0}}};
  assign w_theta = w_inv_sel ? w_raw : -w_raw;
  assign w_quad  = cordic_pkg::quadrant_e'(w_theta[ANGLE_W-1 -: 2]);
  assign w_neg   = (w_quad == cordic_pkg::Q_II) || (w_quad == cordic_pkg::Q_III);
  assign w_angle = w_neg ? {~w_theta[ANGLE_W-1], w_theta[ANGLE_W-2:0]} : w_theta;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= cordic_pkg::ST_IDLE;
      r_k       <= '0;
      r_inverse <= 1'b0;
      r_angle   <= '0;
      r_tag     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_done    <= (r_state == cordic_pkg::ST_DRAIN) && w_last_wr;
      r_tag.valid <= w_issue;
      r_tag.idx   <= IDX_W'(w_k_next);
      r_tag.neg   <= w_neg;
      if (w_accept) r_inverse <= i_inverse;
      if (w_issue) begin
        r_k     <= w_k_next;
        r_angle <= w_angle;
      end
    end
  end

  cordic_tag_delay #(
    .DEPTH (CORDIC_LAT),
    .WIDTH ($bits(cordic_pkg::tag_t))
  ) u_tag_delay (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_data  (r_tag),
    .o_data  (w_tag_out)
  );

  assign w_unused_idx = ^w_tag_out.idx;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tw_we   <= 1'b0;
      r_tw_addr <= '0;
      r_tw_cos  <= '0;
      r_tw_sin  <= '0;
    end else begin
      r_tw_we <= w_tag_out.valid;
      if (w_tag_out.valid) begin
        r_tw_addr <= w_tag_out.idx[LOG2N-1:0];
        r_tw_cos  <= w_tag_out.neg ? sat_neg(i_cosine) : i_cosine;
        r_tw_sin  <= w_tag_out.neg ? sat_neg(i_sine)   : i_sine;
      end
    end
  end

  assign o_angle   = r_angle;
  assign o_x_start = WIDTH'(AMP);
  assign o_y_start = '0;
  assign o_tw_we   = r_tw_we;
  assign o_tw_addr = r_tw_addr;
  assign o_tw_cos  = r_tw_cos;
  assign o_tw_sin  = r_tw_sin;
  assign o_busy    = (r_state != cordic_pkg::ST_IDLE);
  assign o_done    = r_done;
  assign o_state   = r_state;

endmodule

// File: tb/tb_cordic_twiddle_gen.sv
// Bench for cordic_twiddle_gen: behavioural 16-cycle core, real-arithmetic
// twiddle model, per-cycle compare process and directed literal checks.
module tb_cordic_twiddle_gen;

  localparam int  LOG2N = 3;
  localparam int  N     = 8;
  localparam int  WIDTH = 16;
  localparam int  LAT   = 16;
  localparam int  AMP   = 32000;
  localparam real PI    = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic inverse = 1'b0;
  logic [31:0]      angle;
  logic [WIDTH-1:0] x_start, y_start, cosine, sine, tw_cos, tw_sin;
  logic             tw_we, busy, done;
  logic [LOG2N-1:0] tw_addr;
  cordic_pkg::fill_state_e state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit m_check_en = 0;
  bit m_active   = 0;
  bit m_inv      = 0;
  int m_t        = 0;
  logic [34:0]      exp_q[$];
  logic [LOG2N-1:0] m_addr = '0;
  logic [WIDTH-1:0] m_cos = '0, m_sin = '0;
  int n_we_seen   = 0;
  int n_done_seen = 0;
  bit core_force  = 0;

  logic [WIDTH-1:0] cpipe [LAT];
  logic [WIDTH-1:0] spipe [LAT];

  cordic_twiddle_gen #(
    .LOG2N(LOG2N), .WIDTH(WIDTH), .ANGLE_W(32), .CORDIC_LAT(LAT), .AMP(AMP)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_inverse(inverse),
    .o_angle(angle), .o_x_start(x_start), .o_y_start(y_start),
    .i_cosine(cosine), .i_sine(sine),
    .o_tw_we(tw_we), .o_tw_addr(tw_addr), .o_tw_cos(tw_cos), .o_tw_sin(tw_sin),
    .o_busy(busy), .o_done(done), .o_state(state)
  );

  // ---------------- clock / cycle counter ----------------
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- behavioural CORDIC core (16-cycle latency) ----------------
  function automatic logic [WIDTH-1:0] core_val(input logic [31:0] a, input bit is_sin);
    real rad;
    real v;
    rad = real'(int'(a)) * 2.0 * PI / 4294967296.0;
    v   = is_sin ? $sin(rad) : $cos(rad);
    return WIDTH'(rnd(real'(AMP) * v));
  endfunction

  always @(posedge clk) begin
    cpipe[0] <= core_force ? 16'h8000 : core_val(angle, 1'b0);
    spipe[0] <= core_val(angle, 1'b1);
    for (int i = 1; i < LAT; i++) begin
      cpipe[i] <= cpipe[i-1];
      spipe[i] <= spipe[i-1];
    end
  end
  assign cosine = cpipe[LAT-1];
  assign sine   = spipe[LAT-1];

  // ---------------- reference model ----------------
  // Angle of entry k as a fraction of a turn, in units of 1/N turn, in [0, N).
  function automatic int model_units(input int k, input bit inv);
    return inv ? k : (N - k) % N;
  endfunction

  function automatic bit model_neg(input int k, input bit inv);
    int deg;
    deg = model_units(k, inv) * 360 / N;
    return (deg >= 90) && (deg < 270);
  endfunction

  function automatic logic [31:0] model_angle(input int k, input bit inv);
    logic [31:0] th;
    th = 32'(model_units(k, inv)) << (32 - LOG2N);
    return model_neg(k, inv) ? th + cordic_pkg::ANG_180 : th;
  endfunction

  function automatic int model_trig(input int k, input bit inv, input bit is_sin);
    real deg;
    real rad;
    deg = (inv ? 360.0 : -360.0) * real'(k) / real'(N);
    rad = deg * PI / 180.0;
    return rnd(real'(AMP) * (is_sin ? $sin(rad) : $cos(rad)));
  endfunction

  function automatic int model_cos(input int k, input bit inv, input bit force_min);
    if (force_min) return model_neg(k, inv) ? 32767 : -32768;
    return model_trig(k, inv, 1'b0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_fill(input bit inv, input bit force_min);
    start      = 1'b1;
    inverse    = inv;
    core_force = force_min;
    m_t        = cyc;
    m_inv      = inv;
    m_active   = 1'b1;
    for (int k = 0; k < N; k++)
      exp_q.push_back({3'(k), 16'(model_cos(k, inv, force_min)), 16'(model_trig(k, inv, 1'b1))});
    wait_cyc(cyc + 1);
    start   = 1'b0;
    inverse = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wait_cyc(cyc + 1);
    start = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    wait_cyc(cyc + 1);
    rst        = 1'b0;
    m_active   = 1'b0;
    exp_q.delete();
    m_addr     = '0;
    m_cos      = '0;
    m_sin      = '0;
    core_force = 1'b0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_check_en) begin
      bit busy_e, we_e, done_e;
      logic [34:0] e;
      busy_e = m_active && (cyc >= m_t + 1) && (cyc <= m_t + N + LAT + 1);
      we_e   = m_active && (cyc >= m_t + 2 + LAT) && (cyc <= m_t + 1 + LAT + N);
      done_e = m_active && (cyc == m_t + 2 + N + LAT);
      chk("x_start", $signed(x_start), AMP);
      chk("y_start", $signed(y_start), 0);
      chk("busy", busy, busy_e);
      chk("tw_we", tw_we, we_e);
      chk("done", done, done_e);
      if (m_active && (cyc >= m_t + 1) && (cyc <= m_t + N))
        chk("angle", angle, model_angle(cyc - m_t - 1, m_inv));
      if (we_e) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL exp_q_empty at cycle %0d: write expected with no model entry", cyc);
        end else begin
          e      = exp_q.pop_front();
          m_addr = e[34:32];
          m_cos  = e[31:16];
          m_sin  = e[15:0];
        end
      end
      chk("tw_addr", tw_addr, m_addr);
      chk("tw_cos", $signed(tw_cos), $signed(m_cos));
      chk("tw_sin", $signed(tw_sin), $signed(m_sin));
      if (tw_we) n_we_seen++;
      if (done)  n_done_seen++;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: run did not complete within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s;

    // 1: reset held for three edges
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    chk("rst_angle", angle, 0);
    chk("rst_tw_we", tw_we, 0);
    chk("rst_tw_addr", tw_addr, 0);
    chk("rst_tw_cos", tw_cos, 0);
    chk("rst_tw_sin", tw_sin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x_start", x_start, 32000);
    chk("rst_y_start", y_start, 0);
    chk("rst_state", state, cordic_pkg::ST_IDLE);
    m_check_en = 1'b1;

    // 2: forward fill started at cycle 10
    wait_cyc(10);
    start_fill(1'b0, 1'b0);
    chk("fwd_angle_k0", angle, 32'h0000_0000);
    chk("fwd_busy_first", busy, 1);
    wait_cyc(12);
    chk("fwd_angle_k1", angle, 32'hE000_0000);
    wait_cyc(14);
    chk("fwd_angle_k3", angle, 32'h2000_0000);
    wait_cyc(17);
    chk("fwd_angle_k6", angle, 32'hC000_0000);
    wait_cyc(18);
    chk("fwd_angle_k7", angle, 32'h2000_0000);
    wait_cyc(27);
    chk("fwd_no_write_27", tw_we, 0);
    wait_cyc(28);
    chk("fwd_first_write", tw_we, 1);
    chk("fwd_addr_k0", tw_addr, 0);
    chk("fwd_cos_k0", $signed(tw_cos), 32000);
    wait_cyc(30);
    chk("fwd_addr_k2", tw_addr, 2);
    chk("fwd_cos_k2", $signed(tw_cos), 0);
    chk("fwd_sin_k2", $signed(tw_sin), -32000);
    wait_cyc(31);
    chk("fwd_cos_k3", $signed(tw_cos), -22627);
    chk("fwd_sin_k3", $signed(tw_sin), -22627);
    wait_cyc(35);
    chk("fwd_busy_35", busy, 1);
    chk("fwd_addr_k7", tw_addr, 7);
    wait_cyc(36);
    chk("fwd_done_36", done, 1);
    chk("fwd_busy_36", busy, 0);
    wait_cyc(37);
    chk("fwd_done_37", done, 0);

    // 3: inverse fill
    wait_cyc(40);
    s = cyc;
    start_fill(1'b1, 1'b0);
    wait_cyc(s + 3);
    chk("inv_angle_k2", angle, 32'hC000_0000);
    wait_cyc(s + 20);
    chk("inv_cos_k2", $signed(tw_cos), 0);
    chk("inv_sin_k2", $signed(tw_sin), 32000);
    wait_cyc(s + 22);
    chk("inv_cos_k4", $signed(tw_cos), -32000);
    chk("inv_sin_k4", $signed(tw_sin), 0);
    wait_cyc(s + 24);
    chk("inv_cos_k6", $signed(tw_cos), 0);
    chk("inv_sin_k6", $signed(tw_sin), -32000);

    // 4: start pulses while busy and in the done cycle are ignored
    wait_cyc(s + 30);
    s = cyc;
    n_we_seen   = 0;
    n_done_seen = 0;
    start_fill(1'b0, 1'b0);
    wait_cyc(s + 5);
    pulse_start();
    wait_cyc(s + 2 + N + LAT);
    pulse_start();
    wait_cyc(s + 40);
    chk("ign_write_count", n_we_seen, 8);
    chk("ign_done_count", n_done_seen, 1);

    // 5: reset mid-fill, then a fresh fill
    s = cyc;
    n_we_seen   = 0;
    n_done_seen = 0;
    start_fill(1'b0, 1'b0);
    wait_cyc(s + 4);
    reset_pulse();
    chk("abort_busy", busy, 0);
    chk("abort_state", state, cordic_pkg::ST_IDLE);
    wait_cyc(s + 30);
    chk("abort_write_count", n_we_seen, 0);
    chk("abort_done_count", n_done_seen, 0);
    s = cyc;
    n_we_seen   = 0;
    n_done_seen = 0;
    start_fill(1'b1, 1'b0);
    wait_cyc(s + 30);
    chk("refill_write_count", n_we_seen, 8);
    chk("refill_done_count", n_done_seen, 1);

    // 6: saturating negation of the most negative core output
    s = cyc;
    start_fill(1'b0, 1'b1);
    wait_cyc(s + 18);
    chk("sat_cos_k0", $signed(tw_cos), -32768);
    wait_cyc(s + 22);
    chk("sat_addr_k4", tw_addr, 4);
    chk("sat_cos_k4", $signed(tw_cos), 32767);
    wait_cyc(s + 30);
    core_force = 1'b0;

    chk("exp_q_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_twiddle_gen.md
Name: cordic_twiddle_gen

Overview:
- Upstream sequencer and downstream collector wrapped around the rotation-mode CORDIC_main core. Fills the FFT twiddle table used by the phase-correlation FFT/IFFT.
- On start, issues one 32-bit angle per clock for k = 0..N-1, with angle = ∓2πk/N.
- Folds each angle into the core's convergent range (±90°).
- Tracks the core's fixed pipeline latency and writes sign-corrected cos/sin into the twiddle RAM.

Parameters:
- LOG2N, 8, log2 of FFT length N.
- WIDTH, 16, width of x_start/y_start/cosine/sine.
- ANGLE_W, 32, angle width; 2^32 = 360°, 2^30 = 90°.
- CORDIC_LAT, 16, clocks from angle presented to cosine/sine valid at the core outputs.
- AMP, 32000, x_start scale.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin table fill; sampled only when busy=0.
- inverse  in  1  0: angle=-2πk/N (forward FFT); 1: +2πk/N (IFFT); latched at accepted start.
- angle  out  ANGLE_W  to core.
- x_start  out  WIDTH  to core; constant AMP.
- y_start  out  WIDTH  to core; constant 0.
- cosine  in  WIDTH  from core.
- sine  in  WIDTH  from core.
- tw_we  out  1  twiddle RAM write enable.
- tw_addr  out  LOG2N  twiddle index k.
- tw_cos  out  WIDTH  AMP·cos(θk), signed.
- tw_sin  out  WIDTH  AMP·sin(θk), signed.
- busy  out  1  fill in progress.
- done  out  1  one-cycle pulse after last write.

Behaviour:
- Reset values:
  - angle=0, tw_we=0, tw_addr=0, tw_cos=0, tw_sin=0, busy=0, done=0.
  - Tag pipeline cleared.
  - x_start=AMP and y_start=0 at all times.
- States IDLE → ISSUE → DRAIN → IDLE:
  - IDLE: start=1 at cycle t → busy=1 from t+1, latch inverse, k=0.
  - ISSUE: cycles t+1 .. t+N, one angle per cycle; k increments; after k=N-1 go to DRAIN.
  - DRAIN: wait until the tag for k=N-1 emerges.
  - Final write, then done=1 for exactly one cycle; busy=0 in that same cycle; back to IDLE.
  - start while busy=1 is ignored; start in the done cycle is ignored.
- Angle generation:
  - raw = k << (ANGLE_W-LOG2N).
  - θ = inverse ? raw : -raw, two's-complement mod 2^ANGLE_W.
  - Quadrant = θ[31:30]. Values 00 and 11 pass unchanged, neg=0.
  - Values 01 and 10: angle = θ + 2^31 (wrap), neg=1.
  - Exactly +90° (0x40000000) therefore folds to 0xC0000000 with neg=1.
- Tag pipeline:
  - CORDIC_LAT-deep shift register of {valid, k, neg}, advancing every cycle.
  - The entry pushed alongside the angle in cycle c aligns with core outputs in cycle c+CORDIC_LAT.
- Write stage (registered):
  - When the emerging tag is valid, in the next cycle: tw_we=1, tw_addr=k, and tw_cos/tw_sin = neg ? -cosine/-sine : cosine/sine.
  - Negation saturates: -(-2^(WIDTH-1)) → 2^(WIDTH-1)-1.
  - k issued at cycle t+1+k is written at cycle t+2+k+CORDIC_LAT.
  - done at t+2+N+CORDIC_LAT.
  - Total busy span N+CORDIC_LAT+1 cycles.
- Writes are contiguous (one per cycle, no gaps). tw_we=0 outside writes; tw_addr/tw_cos/tw_sin hold their last value.
- reset mid-operation: all tags invalidated. No further tw_we, no done pulse, busy=0 the next cycle.

Decomposition:
- Shared package cordic_pkg:
  - ANGLE_W, AMP, ANG_90=2^30, ANG_180=2^31.
  - Quadrant encodings.
  - Tag struct {valid, idx, neg}.
- One sub-module, cordic_tag_delay: parameterised shift register (depth, width) with synchronous clear.
- The core itself is instantiated by the parent, not inside this block.

Test Plan:
All scenarios use LOG2N=3, CORDIC_LAT=16, and a behavioural core model with 16-cycle latency and rounded AMP·cos/sin.
1. Reset held 3 cycles → all outputs at reset values; x_start=32000, y_start=0.
2. start (inverse=0) at t=10 → angles 0, 0xE0000000, 0xC0000000, 0x20000000(neg), 0x00000000(neg), 0xE0000000(neg), 0x40000000→0xC0000000(neg), 0x20000000 at t=11..18.
   - Writes at 28..35; k=3 → tw_cos=-22627, tw_sin=-22627; k=2 → (0,-32000).
   - done at 36; busy high 11..35, low at 36.
3. inverse=1 fill → k=2 angle 0xC0000000 neg=1 → tw_cos=0, tw_sin=+32000; k=6 → (0,-32000); k=4 → (-32000,0).
4. start pulsed at t+5 and in the done cycle → ignored; exactly 8 writes, one done.
5. reset at t+4 (3 angles issued) → no tw_we afterwards, no done, busy=0 next cycle; a fresh start then completes normally.
6. Core model forced to cosine=-32768 on a neg=1 index → tw_cos=32767.
